// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter (1 or 2 stop bits) that pops one byte per frame from a
// registered-output transmit FIFO and serialises it LSB first onto txd.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rd_d,
    input  logic       rd_empty,
    output logic       rd_en,
    output logic       txd,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_hi_q, stop_hi_d;
    logic          txd_q, txd_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // State register: every flop, including the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            stop_hi_q <= 1'b0;
            txd_q     <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            stop_hi_q <= stop_hi_d;
            txd_q     <= txd_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; FIFO inputs are only looked at while idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_hi_d = stop_hi_q;
        case (state_q)
            IDLE: begin
                if (!rd_empty) begin
                    state_d   = START;
                    shift_d   = rd_d;
                    cnt_d     = '0;
                    idx_d     = '0;
                    stop_hi_d = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    // A second stop bit reuses the bit counter with one extra phase flag.
                    if ((STOP_BITS == 2) && !stop_hi_q) begin
                        stop_hi_d = 1'b1;
                    end else begin
                        stop_hi_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        txd_d   = 1'b1;
        rd_en_d = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        if ((state_q == IDLE) && (state_d == START)) begin
            rd_en_d = 1'b1;
        end
    end

    assign txd   = txd_q;
    assign rd_en = rd_en_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit, one with 2,
// both at 8 clocks per bit; per-cycle samples are checked against hand values.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rd_d1 = 8'h00;
    logic       rd_empty1 = 1'b1;
    logic       rd_en1, txd1, busy1;
    logic [7:0] rd_d2 = 8'h00;
    logic       rd_empty2 = 1'b1;
    logic       rd_en2, txd2, busy2;

    int tests = 0;
    int fails = 0;

    logic tx_s [0:255];
    logic bz_s [0:255];
    logic re_s [0:255];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .rd_d(rd_d1), .rd_empty(rd_empty1),
        .rd_en(rd_en1), .txd(txd1), .busy(busy1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rd_d(rd_d2), .rd_empty(rd_empty2),
        .rd_en(rd_en2), .txd(txd2), .busy(busy2)
    );

    // Byte decoded from mid-bit samples of a frame whose start bit begins at base.
    function automatic logic [7:0] decode(input int base);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = tx_s[base + (k + 1) * 8 + 4];
        return b;
    endfunction

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        tests++;
        if ({txd1, busy1, rd_en1, txd2, busy2, rd_en2} !== 6'b100100) begin
            fails++;
            $display("FAIL reset_state got=%b want=100100", {txd1, busy1, rd_en1, txd2, busy2, rd_en2});
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({txd1, busy1, rd_en1, txd2, busy2, rd_en2} !== 6'b100100) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_1000 bad_cycles=%0d want=0", bad);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({txd1, busy1, rd_en1} !== 3'b100) begin
            fails++;
            $display("FAIL async_reset got=%b want=100", {txd1, busy1, rd_en1});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_byte();
        logic [9:0] lv = 10'b1010101010;
        int pops, bad, bad_idx;
        rd_d1 = 8'h55;
        rd_empty1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tx_s[i] = txd1; bz_s[i] = busy1; re_s[i] = rd_en1;
            if (i == 0) rd_empty1 = 1'b1;
        end
        pops = 0;
        for (int i = 0; i < 100; i++) if (re_s[i]) pops++;
        tests++;
        if (pops != 1 || re_s[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_rd_en pops=%0d first=%b want pops=1 first=1", pops, re_s[0]);
        end
        for (int j = 0; j < 10; j++) begin
            bad = 0;
            for (int c = 0; c < 8; c++) if (tx_s[j * 8 + c] !== lv[j]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL single_level%0d bad_cycles=%0d want level=%b for 8 cycles", j, bad, lv[j]);
            end
        end
        bad = 0;
        for (int i = 80; i < 100; i++) if (tx_s[i] !== 1'b1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL single_idle_tail bad_cycles=%0d want=0", bad);
        end
        bad_idx = -1;
        for (int i = 0; i < 100; i++)
            if (bad_idx < 0 && bz_s[i] !== (i < 80)) bad_idx = i;
        tests++;
        if (bad_idx >= 0) begin
            fails++;
            $display("FAIL single_busy at cycle %0d got=%b want=%b", bad_idx, bz_s[bad_idx], (bad_idx < 80));
        end
        $display("[TB] test_single_byte done (0x55)");
    endtask

    task automatic test_back_to_back();
        int pops, p2, bad, bad_idx;
        logic [7:0] d;
        rd_d1 = 8'hA5;
        rd_empty1 = 1'b0;
        pops = 0;
        p2 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tx_s[i] = txd1; bz_s[i] = busy1; re_s[i] = rd_en1;
            if (rd_en1 === 1'b1) begin
                pops++;
                if (pops == 1) rd_d1 = 8'h3C;
                if (pops == 2) begin
                    rd_empty1 = 1'b1;
                    p2 = i;
                end
            end
        end
        tests++;
        if (pops != 2 || re_s[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_pop_count got=%0d first=%b want=2 first=1", pops, re_s[0]);
        end
        tests++;
        if (p2 != 81) begin
            fails++;
            $display("FAIL b2b_pop_spacing got=%0d want=81", p2);
        end
        d = decode(0);
        tests++;
        if (d !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_byte0 got=%h want=a5", d);
        end
        d = decode(81);
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_byte1 got=%h want=3c", d);
        end
        bad = 0;
        for (int i = 72; i < 81; i++) if (tx_s[i] !== 1'b1) bad++;
        if (tx_s[81] !== 1'b0) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_gap bad_cycles=%0d want 9 high then start", bad);
        end
        bad_idx = -1;
        for (int i = 0; i < 200; i++)
            if (bad_idx < 0 && bz_s[i] !== ((i < 80) || (i >= 81 && i < 161))) bad_idx = i;
        tests++;
        if (bad_idx >= 0) begin
            fails++;
            $display("FAIL b2b_busy at cycle %0d got=%b", bad_idx, bz_s[bad_idx]);
        end
        bad = 0;
        for (int i = 161; i < 200; i++) if (tx_s[i] !== 1'b1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_idle_tail bad_cycles=%0d want=0", bad);
        end
        $display("[TB] test_back_to_back done (0xA5, 0x3C)");
    endtask

    task automatic test_two_stop_bits();
        int pops, busy_cnt, bad_idx;
        rd_d2 = 8'hFF;
        rd_empty2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tx_s[i] = txd2; bz_s[i] = busy2; re_s[i] = rd_en2;
            if (i == 0) rd_empty2 = 1'b1;
        end
        bad_idx = -1;
        for (int i = 0; i < 100; i++)
            if (bad_idx < 0 && tx_s[i] !== (i >= 8)) bad_idx = i;
        tests++;
        if (bad_idx >= 0) begin
            fails++;
            $display("FAIL stop2_txd at cycle %0d got=%b want=%b", bad_idx, tx_s[bad_idx], (bad_idx >= 8));
        end
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) if (bz_s[i]) busy_cnt++;
        tests++;
        if (busy_cnt != 88 || bz_s[87] !== 1'b1 || bz_s[88] !== 1'b0) begin
            fails++;
            $display("FAIL stop2_frame_len got=%0d want=88", busy_cnt);
        end
        pops = 0;
        for (int i = 0; i < 100; i++) if (re_s[i]) pops++;
        tests++;
        if (pops != 1) begin
            fails++;
            $display("FAIL stop2_pops got=%0d want=1", pops);
        end
        $display("[TB] test_two_stop_bits done (0xFF)");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        rd_d1 = 8'h0F;
        rd_empty1 = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            tx_s[i] = txd1; bz_s[i] = busy1;
            if (i == 0) rd_empty1 = 1'b1;
        end
        tests++;
        if (bz_s[35] !== 1'b1 || tx_s[35] !== 1'b1 || tx_s[8] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre busy=%b txd=%b want busy=1 txd=1", bz_s[35], tx_s[35]);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({txd1, busy1, rd_en1} !== 3'b100) begin
            fails++;
            $display("FAIL midrst_async got=%b want=100", {txd1, busy1, rd_en1});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({txd1, busy1, rd_en1} !== 3'b100) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midrst_quiet bad_cycles=%0d want=0", bad);
        end
        $display("[TB] test_reset_mid_frame done (0x0F)");
    endtask

    task automatic test_ignore_mid_frame();
        int early_pops, p2;
        logic [7:0] d;
        rd_d1 = 8'hC3;
        rd_empty1 = 1'b0;
        early_pops = 0;
        p2 = -1;
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            tx_s[i] = txd1; re_s[i] = rd_en1;
            if (i >= 1 && i < 81 && rd_en1 === 1'b1) early_pops++;
            if (i >= 81 && p2 < 0 && rd_en1 === 1'b1) p2 = i;
            if (i < 81) rd_d1 = 8'($urandom);
            if (i >= 1 && i < 79) rd_empty1 = 1'($urandom_range(0, 1));
            else if (i < 81) rd_empty1 = 1'b0;
            else rd_empty1 = 1'b1;
        end
        d = decode(0);
        tests++;
        if (d !== 8'hC3) begin
            fails++;
            $display("FAIL ignore_byte got=%h want=c3", d);
        end
        tests++;
        if (early_pops != 0) begin
            fails++;
            $display("FAIL ignore_early_pop got=%0d want=0", early_pops);
        end
        tests++;
        if (p2 != 81) begin
            fails++;
            $display("FAIL ignore_next_pop got=%0d want=81", p2);
        end
        $display("[TB] test_ignore_mid_frame done (0xC3)");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_two_stop_bits();
        test_reset_mid_frame();
        test_ignore_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
